// File: rtl/conv33_window.sv
// rtl/conv33_window.sv - streaming 3x3 window generator with two line buffers
module conv33_window #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] pix_in,
    input  logic                     pix_valid,
    output logic signed [DATA_W-1:0] data_0_0,
    output logic signed [DATA_W-1:0] data_0_1,
    output logic signed [DATA_W-1:0] data_0_2,
    output logic signed [DATA_W-1:0] data_1_0,
    output logic signed [DATA_W-1:0] data_1_1,
    output logic signed [DATA_W-1:0] data_1_2,
    output logic signed [DATA_W-1:0] data_2_0,
    output logic signed [DATA_W-1:0] data_2_1,
    output logic signed [DATA_W-1:0] data_2_2,
    output logic                     conv33_en,
    output logic                     frame_done,
    output logic [RW-1:0]            row_cnt,
    output logic [CW-1:0]            col_cnt
);

    // lb0 holds the previous row, lb1 the row before that
    logic signed [DATA_W-1:0] lb0 [IMG_W];
    logic signed [DATA_W-1:0] lb1 [IMG_W];
    logic signed [DATA_W-1:0] win [3][3];

    logic accept;
    logic last_col;
    logic last_row;
    logic full_window;

    // clear wins over a coincident pixel, which is dropped
    assign accept      = pix_valid && !clear;
    assign last_col    = (col_cnt == CW'(IMG_W - 1));
    assign last_row    = (row_cnt == RW'(IMG_H - 1));
    assign full_window = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

    // line buffers are plain RAM: no reset, stale data is masked by row_cnt
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_cnt] <= lb0[col_cnt];
            lb0[col_cnt] <= pix_in;
        end
    end

    // shift the window one column left and load the new column on the right
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb1[col_cnt];
            win[1][2] <= lb0[col_cnt];
            win[2][2] <= pix_in;
        end
    end

    // raster position counters and the registered window/frame strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt    <= '0;
            col_cnt    <= '0;
            conv33_en  <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            row_cnt    <= '0;
            col_cnt    <= '0;
            conv33_en  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            conv33_en  <= accept && full_window;
            frame_done <= accept && last_row && last_col;
            if (accept) begin
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end

    assign data_0_0 = win[0][0];
    assign data_0_1 = win[0][1];
    assign data_0_2 = win[0][2];
    assign data_1_0 = win[1][0];
    assign data_1_1 = win[1][1];
    assign data_1_2 = win[1][2];
    assign data_2_0 = win[2][0];
    assign data_2_1 = win[2][1];
    assign data_2_2 = win[2][2];

endmodule

// File: tb/tb_conv33_window.sv
// tb/tb_conv33_window.sv - scoreboard bench for conv33_window
module tb_conv33_window;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic [DW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
    logic          conv33_en;
    logic          frame_done;
    logic [1:0]    row_cnt;
    logic [2:0]    col_cnt;

    conv33_window #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .pix_in(pix_in), .pix_valid(pix_valid),
        .data_0_0(d00), .data_0_1(d01), .data_0_2(d02),
        .data_1_0(d10), .data_1_1(d11), .data_1_2(d12),
        .data_2_0(d20), .data_2_1(d21), .data_2_2(d22),
        .conv33_en(conv33_en), .frame_done(frame_done),
        .row_cnt(row_cnt), .col_cnt(col_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] due;
        logic [71:0] win;
        logic        fd;
    } exp_t;

    exp_t        q [$];
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        exp_en;
    exp_t        e;
    wire [71:0]  got_win = {d00, d01, d02, d10, d11, d12, d20, d21, d22};

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // scoreboard: every cycle the strobe must match whether a window is due
    always @(negedge clk) begin
        if (rst) begin
            exp_en = (q.size() > 0) && (q[0].due == 32'(cyc));
            check("en", {71'b0, conv33_en}, {71'b0, exp_en});
            if (exp_en) begin
                e = q.pop_front();
                check("fd", {71'b0, frame_done}, {71'b0, e.fd});
                if (conv33_en) begin
                    pulses++;
                    check("win", got_win, e.win);
                end
            end else begin
                check("fd_idle", {71'b0, frame_done}, 72'b0);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] p, input logic c);
        exp_t x;
        @(negedge clk);
        pix_valid = v;
        pix_in    = p;
        clear     = c;
        if (c) begin
            mr = 0;
            mc = 0;
        end else if (v) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                x.due = 32'(cyc + 1);
                x.fd  = (mr == H - 1) && (mc == W - 1);
                x.win = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        x.win = {x.win[63:0], img[mr-2+i][mc-2+j]};
                q.push_back(x);
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic frame(input int offset, input bit bubbles, input bit neg, input int npix);
        for (int k = 0; k < npix; k++) begin
            if (bubbles) drive(1'b0, 8'h00, 1'b0);
            drive(1'b1, neg ? 8'hFF : 8'(k + 1 + offset), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b0);
    endtask

    int p0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_win", got_win, 72'b0);
        check("rst_en", {71'b0, conv33_en}, 72'b0);
        check("rst_fd", {71'b0, frame_done}, 72'b0);
        check("rst_pos", {66'b0, row_cnt, col_cnt, 1'b0}, 72'b0);
        rst = 1'b1;

        // counting frame
        p0 = pulses;
        frame(0, 1'b0, 1'b0, W * H);
        idle(2);
        check("cnt_pulses", 72'(pulses - p0), 72'd6);

        // all -1 pixels
        p0 = pulses;
        frame(0, 1'b0, 1'b1, W * H);
        idle(2);
        check("neg_pulses", 72'(pulses - p0), 72'd6);
        check("neg_win", got_win, {9{8'hFF}});

        // bubbles every other cycle
        p0 = pulses;
        frame(0, 1'b1, 1'b0, W * H);
        idle(2);
        check("bub_pulses", 72'(pulses - p0), 72'd6);

        // back-to-back frames, second offset by 100
        p0 = pulses;
        frame(0, 1'b0, 1'b0, W * H);
        frame(100, 1'b0, 1'b0, W * H);
        idle(2);
        check("b2b_pulses", 72'(pulses - p0), 72'd12);

        // clear coincident with pixel (2,3)
        p0 = pulses;
        frame(0, 1'b0, 1'b0, 2 * W + 3);
        drive(1'b1, 8'd14, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        check("clr_pos", {66'b0, row_cnt, col_cnt, 1'b0}, 72'b0);
        check("clr_pulses", 72'(pulses - p0), 72'd1);
        p0 = pulses;
        frame(0, 1'b0, 1'b0, W * H);
        idle(2);
        check("clr_frame", 72'(pulses - p0), 72'd6);

        // async reset pulse between edges during row 3
        frame(0, 1'b0, 1'b0, 3 * W + 2);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_win", got_win, 72'b0);
        check("arst_en", {71'b0, conv33_en}, 72'b0);
        check("arst_pos", {66'b0, row_cnt, col_cnt, 1'b0}, 72'b0);
        q.delete();
        mr = 0;
        mc = 0;
        pix_valid = 1'b0;
        #1 rst = 1'b1;
        p0 = pulses;
        frame(0, 1'b0, 1'b0, W * H);
        idle(2);
        check("arst_frame", 72'(pulses - p0), 72'd6);
        check("drain", 72'(q.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
